data_sram_rsp: RTL

// - Responder end of the data-SRAM port driven by the MEM stage: accepts byte-strobed stores and word reads.
// - Store bytes commit at acceptance; reads return rdata after a fixed pipeline latency through a response FIFO.
// - Sits behind MEM stage as data memory; used in the CPU top and as the bench memory for pipeline tests.

---
 rtl/data_sram_rsp_pkg.sv | 24 ++
 rtl/data_sram_rsp_rsp_fifo.sv | 56 +++++
 rtl/data_sram_rsp.sv | 115 +++++++++++
 3 files changed

// File: rtl/data_sram_rsp_pkg.sv
// Shared definitions for the data-SRAM responder.
// - Byte-strobe encodings accepted on req_we.
// - be_legal(): 1 when a nonzero strobe is a legal aligned byte/half/word store.
package data_sram_rsp_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
      default:                                        be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_rsp_rsp_fifo.sv
// Synchronous response FIFO.
// Ports: clk, resetn (async low, clears pointers/count), push/wdata, pop (ignored
// when empty), rdata (reads 0 while empty), count, empty, full.
// A push while full is legal only together with a pop; the slot being written
// is the one that is being consumed at that same edge.
module rsp_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    nxt = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign rdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_rsp.sv
// Data-SRAM responder behind the MEM stage.
// Ports: clk, resetn (async low); request channel req_valid/req_ready/req_we/
// req_addr/req_wdata; response channel rsp_valid/rsp_ready/rsp_rdata;
// err_sticky flags any illegal strobe until reset.
// Stores commit at the accept edge. Reads sample the array at the accept edge and
// reach the response FIFO LATENCY-1 edges later, so rsp_valid rises exactly
// LATENCY cycles after acceptance. Credit (reads in pipe + FIFO occupancy) gates
// req_ready so the pipe never has to stall.
module data_sram_rsp
  import data_sram_rsp_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        err_sticky
);

  localparam int WORDS  = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(RSP_DEPTH + LATENCY + 1);
  localparam int FCNT_W = $clog2(RSP_DEPTH + 1);

  logic                               en_q;
  logic                               accept, is_rd, is_st, wr_ok;
  logic [ADDR_W-1:0]                  idx;
  logic [NUM_LANES-1:0][LANE_W-1:0]   rd_word;
  logic                               push;
  logic [31:0]                        push_data;
  logic [CNT_W-1:0]                   pipe_cnt, outstanding;
  logic [FCNT_W-1:0]                  fcount;
  logic                               f_empty, f_full;

  assign idx    = req_addr[ADDR_W+1:2];
  assign accept = req_valid && req_ready;
  assign is_st  = accept && (req_we != 4'b0000);
  assign is_rd  = accept && (req_we == 4'b0000);
  assign wr_ok  = is_st && be_legal(req_we);

  // One byte bank per lane keeps each lane's write port independent.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] bank [WORDS];
    always_ff @(posedge clk) begin
      if (wr_ok && req_we[l]) bank[idx] <= req_wdata[l*LANE_W +: LANE_W];
    end
    assign rd_word[l] = bank[idx];
  end

  // Latency pipe: LATENCY-1 registered stages between array sample and FIFO.
  if (LATENCY == 1) begin : g_nopipe
    assign push      = is_rd;
    assign push_data = rd_word;
    assign pipe_cnt  = '0;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 2;
    logic [STAGES:0]       vld_pipe;
    logic [STAGES:0][31:0] dat_pipe;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= is_rd;
        for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
    end
    always_ff @(posedge clk) begin
      dat_pipe[0] <= rd_word;
      for (int s = 1; s <= STAGES; s++) dat_pipe[s] <= dat_pipe[s-1];
    end
    assign push      = vld_pipe[STAGES];
    assign push_data = dat_pipe[STAGES];
    assign pipe_cnt  = CNT_W'($countones(vld_pipe));
  end

  rsp_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (push_data),
    .pop    (rsp_ready),
    .rdata  (rsp_rdata),
    .count  (fcount),
    .empty  (f_empty),
    .full   (f_full)
  );

  assign rsp_valid   = !f_empty;
  assign outstanding = pipe_cnt + CNT_W'(fcount);
  // en_q holds req_ready low through reset and releases it on the first edge after.
  assign req_ready   = en_q && (outstanding < CNT_W'(RSP_DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q       <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (is_st && !be_legal(req_we)) err_sticky <= 1'b1;
    end
  end

  // Credit must keep a free slot for every read leaving the pipe.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && f_full && !rsp_ready));

endmodule
